// File: rtl/stream_beat_source.sv
// Ready/valid beat generator: on start, emits `count` beats whose two payload fields
// advance by independent arithmetic steps, honouring downstream backpressure.
module stream_beat_source #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DATA2_WIDTH = 13,
    parameter int unsigned LEN_WIDTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic        [LEN_WIDTH-1:0]   count,
    input  logic        [DATA_WIDTH-1:0]  data_seed,
    input  logic        [DATA_WIDTH-1:0]  data_step,
    input  logic signed [DATA2_WIDTH-1:0] data2_seed,
    input  logic signed [DATA2_WIDTH-1:0] data2_step,
    output logic        [DATA_WIDTH-1:0]  out_data,
    output logic signed [DATA2_WIDTH-1:0] out_data2,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [0:0] {StIdle, StSend} state_e;

    state_e                          state_q;
    logic        [LEN_WIDTH-1:0]     remaining_q;
    logic        [DATA_WIDTH-1:0]    data_step_q;
    logic signed [DATA2_WIDTH-1:0]   data2_step_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            remaining_q  <= '0;
            data_step_q  <= '0;
            data2_step_q <= '0;
            out_data     <= '0;
            out_data2    <= '0;
            out_valid    <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        if (count != '0) begin
                            remaining_q  <= count;
                            out_data     <= data_seed;
                            out_data2    <= data2_seed;
                            data_step_q  <= data_step;
                            data2_step_q <= data2_step;
                            out_valid    <= 1'b1;
                            busy         <= 1'b1;
                            state_q      <= StSend;
                        end else begin
                            // Empty burst still completes, just without beats.
                            done <= 1'b1;
                        end
                    end
                end
                StSend: begin
                    if (out_valid && out_ready) begin
                        if (remaining_q > LEN_WIDTH'(1)) begin
                            remaining_q <= remaining_q - LEN_WIDTH'(1);
                            out_data    <= out_data + data_step_q;
                            out_data2   <= out_data2 + data2_step_q;
                        end else begin
                            // Payload holds the last beat; only the handshake drops.
                            remaining_q <= '0;
                            out_valid   <= 1'b0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                            state_q     <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_beat_source.sv
// Directed bench for stream_beat_source: one task per scenario with inline checks.
module tb_stream_beat_source;

    localparam int DW  = 16;
    localparam int D2W = 13;
    localparam int LW  = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic        [LW-1:0]  count;
    logic        [DW-1:0]  data_seed;
    logic        [DW-1:0]  data_step;
    logic signed [D2W-1:0] data2_seed;
    logic signed [D2W-1:0] data2_step;
    logic        [DW-1:0]  out_data;
    logic signed [D2W-1:0] out_data2;
    logic                  out_valid;
    logic                  out_ready;
    logic                  busy;
    logic                  done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    stream_beat_source #(
        .DATA_WIDTH (DW),
        .DATA2_WIDTH(D2W),
        .LEN_WIDTH  (LW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .count     (count),
        .data_seed (data_seed),
        .data_step (data_step),
        .data2_seed(data2_seed),
        .data2_step(data2_step),
        .out_data  (out_data),
        .out_data2 (out_data2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [LW-1:0] n, input logic [DW-1:0] ds, input logic [DW-1:0] dt,
                        input logic signed [D2W-1:0] d2s, input logic signed [D2W-1:0] d2t);
        count      = n;
        data_seed  = ds;
        data_step  = dt;
        data2_seed = d2s;
        data2_step = d2t;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        start     = 1'b0;
        out_ready = 1'b0;
        load(8'd0, 16'h0, 16'h0, 13'sd0, 13'sd0);
        #12;
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", out_valid); end
        total++;
        if (out_data !== 16'h0) begin bad++; $display("FAIL reset_data got %h want 0000", out_data); end
        total++;
        if (out_data2 !== 13'sd0) begin bad++; $display("FAIL reset_data2 got %0d want 0", out_data2); end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_busy_done got busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        total++;
        if (out_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("FAIL reset_idle got valid=%b done=%b want 0 0", out_valid, done);
        end
    endtask

    task automatic test_basic();
        logic        [DW-1:0]  exp_d  [4];
        logic signed [D2W-1:0] exp_d2 [4];
        exp_d  = '{16'h0010, 16'h0013, 16'h0016, 16'h0019};
        exp_d2 = '{-13'sd2, -13'sd1, 13'sd0, 13'sd1};
        load(8'd4, 16'h0010, 16'h0003, -13'sd2, 13'sd1);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            total++;
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                out_data !== exp_d[i] || out_data2 !== exp_d2[i]) begin
                bad++;
                $display("FAIL basic_beat%0d got v=%b b=%b dn=%b d=%h d2=%0d want v=1 b=1 dn=0 d=%h d2=%0d",
                         i, out_valid, busy, done, out_data, out_data2, exp_d[i], exp_d2[i]);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL basic_done got dn=%b v=%b b=%b want 1 0 0", done, out_valid, busy);
        end
        total++;
        if (out_data !== 16'h0019 || out_data2 !== 13'sd1) begin
            bad++; $display("FAIL basic_hold got d=%h d2=%0d want 0019 1", out_data, out_data2);
        end
        tick();
        total++;
        if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        logic        [DW-1:0]  exp_d  [4];
        logic signed [D2W-1:0] exp_d2 [4];
        logic                  pat    [7];
        int                    idx;
        exp_d  = '{16'h0010, 16'h0013, 16'h0016, 16'h0019};
        exp_d2 = '{-13'sd2, -13'sd1, 13'sd0, 13'sd1};
        pat    = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        idx    = 0;
        load(8'd4, 16'h0010, 16'h0003, -13'sd2, 13'sd1);
        out_ready = 1'b0;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            out_ready = pat[k];
            total++;
            if (out_valid !== 1'b1 || done !== 1'b0 ||
                out_data !== exp_d[idx] || out_data2 !== exp_d2[idx]) begin
                bad++;
                $display("FAIL bp_cycle%0d got v=%b dn=%b d=%h d2=%0d want v=1 dn=0 d=%h d2=%0d",
                         k, out_valid, done, out_data, out_data2, exp_d[idx], exp_d2[idx]);
            end
            tick();
            if (pat[k]) idx++;
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL bp_done got dn=%b v=%b want 1 0", done, out_valid);
        end
        out_ready = 1'b1;
        tick();
    endtask

    task automatic test_wrap();
        logic        [DW-1:0]  exp_d  [3];
        logic signed [D2W-1:0] exp_d2 [3];
        exp_d  = '{16'hFFFE, 16'hFFFF, 16'h0000};
        exp_d2 = '{13'sd4094, 13'sd4095, -13'sd4096};
        load(8'd3, 16'hFFFE, 16'h0001, 13'sd4094, 13'sd1);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (out_valid !== 1'b1 || out_data !== exp_d[i] || out_data2 !== exp_d2[i]) begin
                bad++;
                $display("FAIL wrap_beat%0d got v=%b d=%h d2=%0d want v=1 d=%h d2=%0d",
                         i, out_valid, out_data, out_data2, exp_d[i], exp_d2[i]);
            end
            tick();
        end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL wrap_done got %b want 1", done); end
        tick();
    endtask

    task automatic test_zero_count();
        load(8'd0, 16'h1111, 16'h0001, 13'sd5, 13'sd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL zero_done got dn=%b b=%b v=%b want 1 0 0", done, busy, out_valid);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            bad++; $display("FAIL zero_after got dn=%b b=%b v=%b want 0 0 0", done, busy, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic        [DW-1:0]  exp_d  [5];
        logic signed [D2W-1:0] exp_d2 [5];
        exp_d  = '{16'h0100, 16'h0110, 16'h0120, 16'h0130, 16'h0140};
        exp_d2 = '{13'sd100, 13'sd93, 13'sd86, 13'sd79, 13'sd72};
        load(8'd5, 16'h0100, 16'h0010, 13'sd100, -13'sd7);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // Tempting start pulses while busy, including the final transfer edge.
            if (i == 2 || i == 4) begin
                load(8'd2, 16'h0A00, 16'h0001, -13'sd5, 13'sd2);
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            total++;
            if (out_valid !== 1'b1 || done !== 1'b0 ||
                out_data !== exp_d[i] || out_data2 !== exp_d2[i]) begin
                bad++;
                $display("FAIL b2b_beat%0d got v=%b dn=%b d=%h d2=%0d want v=1 dn=0 d=%h d2=%0d",
                         i, out_valid, done, out_data, out_data2, exp_d[i], exp_d2[i]);
            end
            tick();
        end
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_done got dn=%b v=%b want 1 0", done, out_valid);
        end
        tick();
        start = 1'b0;
        total++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
            out_data !== 16'h0A00 || out_data2 !== -13'sd5) begin
            bad++;
            $display("FAIL b2b_next0 got v=%b b=%b dn=%b d=%h d2=%0d want 1 1 0 0a00 -5",
                     out_valid, busy, done, out_data, out_data2);
        end
        tick();
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0A01 || out_data2 !== -13'sd3) begin
            bad++;
            $display("FAIL b2b_next1 got v=%b d=%h d2=%0d want 1 0a01 -3", out_valid, out_data, out_data2);
        end
        tick();
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_next_done got dn=%b v=%b want 1 0", done, out_valid);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        load(8'd6, 16'h0040, 16'h0002, -13'sd10, 13'sd3);
        out_ready = 1'b1;
        start     = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h0044 || out_data2 !== -13'sd4) begin
            bad++;
            $display("FAIL rmid_beat2 got v=%b d=%h d2=%0d want 1 0044 -4", out_valid, out_data, out_data2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 16'h0 || out_data2 !== 13'sd0) begin
            bad++;
            $display("FAIL rmid_async got v=%b b=%b d=%h d2=%0d want 0 0 0000 0",
                     out_valid, busy, out_data, out_data2);
        end
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rmid_quiet%0d got v=%b dn=%b b=%b want 0 0 0", i, out_valid, done, busy);
            end
        end
        load(8'd1, 16'h1234, 16'h0000, 13'sd7, 13'sd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        total++;
        if (out_valid !== 1'b1 || out_data !== 16'h1234 || out_data2 !== 13'sd7) begin
            bad++;
            $display("FAIL rmid_restart got v=%b d=%h d2=%0d want 1 1234 7", out_valid, out_data, out_data2);
        end
        tick();
        total++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            bad++; $display("FAIL rmid_restart_done got dn=%b v=%b want 1 0", done, out_valid);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_zero_count();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/stream_beat_source.md
Name: stream_beat_source

Overview:
Transmit-side endpoint for the composite ready/valid stream (unsigned `data`, signed `data2`, `valid`, `ready`).
- On a start request, emits a programmed number of beats.
- Each beat carries arithmetic-progression payloads on both fields.
- Obeys downstream backpressure.
- Drives stream inputs of composite-interface blocks in bring-up and loopback configurations; pairs with any receiver of the same interface.

Parameters:
DATA_WIDTH, 16, width of unsigned `out_data` field
DATA2_WIDTH, 13, width of signed `out_data2` field
LEN_WIDTH, 8, width of beat-count input and internal remaining counter

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin a burst; sampled only in IDLE
count  input  LEN_WIDTH  number of beats in burst, sampled with start
data_seed  input  DATA_WIDTH  `out_data` value of beat 0
data_step  input  DATA_WIDTH  unsigned increment per beat
data2_seed  input  signed DATA2_WIDTH  `out_data2` value of beat 0
data2_step  input  signed DATA2_WIDTH  signed increment per beat
out_data  output  DATA_WIDTH  stream payload field 1
out_data2  output  signed DATA2_WIDTH  stream payload field 2
out_valid  output  1  stream valid
out_ready  input  1  stream ready from downstream
busy  output  1  high while a burst is in progress
done  output  1  one-cycle pulse after burst completes

Behaviour:
- Reset (async assert, sync release):
  - `out_valid`=0, `out_data`=0, `out_data2`=0, `busy`=0, `done`=0.
  - FSM=IDLE, remaining=0.
  - Reset mid-burst drops `out_valid` immediately; the partial burst is abandoned and no `done` is produced.
- FSM states: IDLE, SEND.
  - IDLE and `start`=1 and `count`!=0:
    - Latch `count` into remaining.
    - Load `out_data`=`data_seed`, `out_data2`=`data2_seed`.
    - Latch both steps.
    - Next cycle: SEND, `out_valid`=1, `busy`=1.
  - IDLE and `start`=1 and `count`==0:
    - No beats emitted.
    - `done`=1 for one cycle, starting the cycle after `start`.
    - Remain in IDLE; `busy` stays 0.
  - SEND: a transfer occurs on any rising edge with `out_valid`=1 and `out_ready`=1.
  - On a transfer with remaining>1:
    - remaining -= 1.
    - `out_data` += step, wrapping mod 2^DATA_WIDTH.
    - `out_data2` += step, two's-complement wrap in DATA2_WIDTH (e.g. 4095+1 -> -4096).
    - `out_valid` stays 1, giving back-to-back beats at one per cycle.
  - On a transfer with remaining==1:
    - Next cycle: `out_valid`=0, `busy`=0, `done`=1 for exactly one cycle.
    - FSM=IDLE; payload registers hold the last beat value.
- Handshake rules:
  - `out_valid` never deasserts without a transfer.
  - `out_data`/`out_data2` are stable while `out_valid`=1 and `out_ready`=0.
  - `out_valid` does not depend combinationally on `out_ready`; all outputs are registered.
- Input sampling:
  - `start` is ignored while `busy`=1 (including the completion cycle's preceding transfer edge).
  - `count`, seeds and steps are sampled only on an accepted `start`.
- Next burst timing: earliest next burst is `start` in the `done` cycle; its first beat is valid one cycle later.
- Latency: `start` to first `out_valid` = 1 cycle. Total cycles with zero backpressure = `count` + 1 to `done`.
- Maximum burst: 2^LEN_WIDTH-1 beats.

Test Plan:
1. Reset then `start` with count=4, data_seed=0x0010, data_step=0x0003, data2_seed=-2, data2_step=+1, `out_ready`=1 constantly -> beats (0x0010,-2),(0x0013,-1),(0x0016,0),(0x0019,1) on 4 consecutive cycles; `done` pulses the cycle after the last beat.
2. Same burst with `out_ready` toggling 1,0,0,1,0,1,1 -> exactly 4 transfers; payload and `out_valid` held constant through every stall; no beat duplicated or skipped.
3. Wrap: data_seed=0xFFFE, data_step=1, data2_seed=4094, data2_step=1, count=3 -> `out_data` 0xFFFE,0xFFFF,0x0000; `out_data2` 4094,4095,-4096.
4. count=0 with `start` -> `out_valid` never rises, `busy` stays 0, `done` high for one cycle.
5. `start` pulsed during an active burst of 5 -> ignored; exactly 5 beats and one `done`. Then `start` in the `done` cycle -> new burst's first beat valid the next cycle.
6. Assert `rst_n`=0 after beat 2 of 6 while `out_ready`=0 -> `out_valid`, `busy`, payload go to 0 asynchronously; after release, no beats and no `done` until a new `start`.
